// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and forwarding controller for the five-stage integer pipeline.
//
// A shadow copy of the writeback metadata {valid, wreg, m2reg, dest} for the
// EX, MEM and WB stages is used to detect:
//   - load-use hazards (stall + bubble for one cycle)
//   - multi-cycle ALU occupancy (EX held for MulLatency cycles)
// It also produces registered operand forwarding selects for EX.
//
// Ports:
//   clk_i, rst_i         clock (rising edge), asynchronous active-high reset
//   flush_i              kill the instruction in ID
//   id_*                 decoded instruction metadata in ID
//   stall_o              hold PC and IF/ID
//   bubble_o             load a NOP into ID/EX
//   ex_busy_o            EX occupied by a multi-cycle op
//   fwd_a_o, fwd_b_o     00 regfile, 01 MEM aluresult, 10 WB data
//   stall_cnt_o          stall-cycle counter
//
// Build option: define HAZARD_PERF_CNT_EN to build the saturating stall-cycle
// counter; otherwise stall_cnt_o is tied to zero.
module pipeline_hazard_ctrl #(
  parameter int unsigned RegAddrW   = 5,
  parameter int unsigned MulLatency = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                id_valid_i,
  input  logic [RegAddrW-1:0] id_rs_i,
  input  logic [RegAddrW-1:0] id_rt_i,
  input  logic                id_use_rs_i,
  input  logic                id_use_rt_i,
  input  logic                id_wreg_i,
  input  logic                id_m2reg_i,
  input  logic [RegAddrW-1:0] id_dest_i,
  input  logic                id_multicycle_i,
  output logic                stall_o,
  output logic                bubble_o,
  output logic                ex_busy_o,
  output logic [1:0]          fwd_a_o,
  output logic [1:0]          fwd_b_o,
  output logic [15:0]         stall_cnt_o
);

  typedef struct packed {
    logic                valid;
    logic                wreg;
    logic                m2reg;
    logic [RegAddrW-1:0] dest;
  } entry_t;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  localparam logic [1:0] FwdRf  = 2'b00;
  localparam logic [1:0] FwdMem = 2'b01;
  localparam logic [1:0] FwdWb  = 2'b10;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  entry_t     ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;

  entry_t id_entry;
  logic   busy, advance, load_use;
  logic   match_a_ex, match_b_ex, match_a_mem, match_b_mem;

  function automatic logic src_match(input logic use_f, input logic [RegAddrW-1:0] src,
                                     input entry_t e);
    return use_f && e.valid && e.wreg && (e.dest == src) && (src != '0);
  endfunction

  always_comb begin
    match_a_ex  = src_match(id_use_rs_i, id_rs_i, ex_q);
    match_b_ex  = src_match(id_use_rt_i, id_rt_i, ex_q);
    match_a_mem = src_match(id_use_rs_i, id_rs_i, mem_q);
    match_b_mem = src_match(id_use_rt_i, id_rt_i, mem_q);

    busy     = (state_q == StBusy);
    // The last BUSY cycle releases EX on the same edge the counter expires.
    advance  = !busy || (cnt_q == 4'd0);
    load_use = id_valid_i && ex_q.m2reg && (match_a_ex || match_b_ex);

    // BUSY dominates load-use; a flush removes the consumer so nothing is held.
    stall_o   = busy || (load_use && !flush_i);
    bubble_o  = !busy && load_use;
    ex_busy_o = busy;

    // A stalled instruction stays in ID, so what enters EX is a bubble.
    id_entry.valid = id_valid_i && !flush_i && !stall_o;
    id_entry.wreg  = id_wreg_i;
    id_entry.m2reg = id_m2reg_i;
    id_entry.dest  = id_dest_i;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wb_d    = mem_q;
    mem_d   = ex_q;
    ex_d    = id_entry;
    fwd_a_d = FwdRf;
    fwd_b_d = FwdRf;

    unique case (state_q)
      StIdle: begin
        if (id_entry.valid && id_multicycle_i) begin
          state_d = StBusy;
          cnt_d   = 4'(MulLatency - 1);
        end
      end
      StBusy: begin
        if (cnt_q == 4'd0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (!advance) begin
      // EX holds the multi-cycle op; MEM drains with invalid entries.
      ex_d    = ex_q;
      mem_d   = '0;
      fwd_a_d = fwd_a_q;
      fwd_b_d = fwd_b_q;
    end else if (id_entry.valid) begin
      // Youngest producer wins; a load in EX never forwards (load-use bubbles).
      if (match_a_ex && !ex_q.m2reg) fwd_a_d = FwdMem;
      else if (match_a_mem)          fwd_a_d = FwdWb;
      if (match_b_ex && !ex_q.m2reg) fwd_b_d = FwdMem;
      else if (match_b_mem)          fwd_b_d = FwdWb;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      fwd_a_q <= FwdRf;
      fwd_b_q <= FwdRf;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign fwd_a_o = fwd_a_q;
  assign fwd_b_o = fwd_b_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= 16'h0000;
    end else if (stall_o && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       flush_i = 1'b0;
  logic       id_valid_i = 1'b0;
  logic [4:0] id_rs_i = '0, id_rt_i = '0, id_dest_i = '0;
  logic       id_use_rs_i = 1'b0, id_use_rt_i = 1'b0;
  logic       id_wreg_i = 1'b0, id_m2reg_i = 1'b0, id_multicycle_i = 1'b0;
  logic       stall_o, bubble_o, ex_busy_o;
  logic [1:0] fwd_a_o, fwd_b_o;
  logic [15:0] stall_cnt_o;

  pipeline_hazard_ctrl #(.RegAddrW(5), .MulLatency(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .id_valid_i(id_valid_i),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_use_rs_i(id_use_rs_i),
    .id_use_rt_i(id_use_rt_i), .id_wreg_i(id_wreg_i), .id_m2reg_i(id_m2reg_i),
    .id_dest_i(id_dest_i), .id_multicycle_i(id_multicycle_i), .stall_o(stall_o),
    .bubble_o(bubble_o), .ex_busy_o(ex_busy_o), .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o),
    .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       tag;
    logic        stall;
    logic        bubble;
    logic        busy;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   stall_total = 0;

  task automatic cmp(input string tag, input string what, input logic [15:0] got,
                     input logic [15:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, got, want);
    end
  endtask

  task automatic push_exp(input string tag, input logic s, input logic b, input logic bz,
                          input logic [1:0] fa, input logic [1:0] fb);
    exp_t e;
    if (s) stall_total++;
    e.tag = tag; e.stall = s; e.bubble = b; e.busy = bz; e.fa = fa; e.fb = fb;
`ifdef HAZARD_PERF_CNT_EN
    // Counter value seen this cycle covers stalls of earlier cycles only.
    e.cnt = 16'(s ? stall_total - 1 : stall_total);
`else
    e.cnt = 16'h0000;
`endif
    exp_q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard observed=empty expected=entry");
      return;
    end
    e = exp_q.pop_front();
    cmp(e.tag, "stall", 16'(stall_o), 16'(e.stall));
    cmp(e.tag, "bubble", 16'(bubble_o), 16'(e.bubble));
    cmp(e.tag, "busy", 16'(ex_busy_o), 16'(e.busy));
    cmp(e.tag, "fwd_a", 16'(fwd_a_o), 16'(e.fa));
    cmp(e.tag, "fwd_b", 16'(fwd_b_o), 16'(e.fb));
    cmp(e.tag, "stall_cnt", stall_cnt_o, e.cnt);
  endtask

  // One cycle: drive ID contents, queue the expected outputs, sample at negedge.
  task automatic step(input string tag, input logic v, input logic [4:0] rs,
                      input logic urs, input logic [4:0] rt, input logic urt,
                      input logic w, input logic m2, input logic [4:0] d, input logic mc,
                      input logic fl, input logic s, input logic b, input logic bz,
                      input logic [1:0] fa, input logic [1:0] fb);
    id_valid_i = v; id_rs_i = rs; id_use_rs_i = urs; id_rt_i = rt; id_use_rt_i = urt;
    id_wreg_i = w; id_m2reg_i = m2; id_dest_i = d; id_multicycle_i = mc; flush_i = fl;
    push_exp(tag, s, b, bz, fa, fb);
    @(negedge clk_i);
    pop_check();
    @(posedge clk_i);
    #1;
  endtask

  task automatic nop(input string tag, input logic s, input logic bz, input logic [1:0] fa,
                     input logic [1:0] fb);
    step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, s, 0, bz, fa, fb);
  endtask

  initial begin
    repeat (2) @(posedge clk_i);
    #2 rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    nop("reset", 0, 0, 2'b00, 2'b00);

    // Back-to-back ALU forwarding
    step("alu_i1", 1, 1, 1, 2, 1, 1, 0, 3, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    step("alu_i2", 1, 3, 1, 4, 1, 1, 0, 6, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    step("alu_i3", 1, 3, 1, 0, 0, 1, 0, 7, 0, 0, 0, 0, 0, 2'b01, 2'b00);
    nop("alu_i3_ex", 0, 0, 2'b10, 2'b00);
    nop("alu_drain", 0, 0, 2'b00, 2'b00);

    // Load-use on rt
    step("ld", 1, 1, 1, 0, 0, 1, 1, 5, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    step("lu_stall", 1, 2, 1, 5, 1, 1, 0, 8, 0, 0, 1, 1, 0, 2'b00, 2'b00);
    step("lu_release", 1, 2, 1, 5, 1, 1, 0, 8, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    nop("lu_consumer_ex", 0, 0, 2'b00, 2'b10);
    nop("lu_drain", 0, 0, 2'b00, 2'b00);

    // Register 0 never matches
    step("r0_prod", 1, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    step("r0_cons", 1, 0, 1, 0, 1, 1, 0, 9, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    nop("r0_cons_ex", 0, 0, 2'b00, 2'b00);
    nop("r0_drain", 0, 0, 2'b00, 2'b00);

    // Multi-cycle op, MulLatency=4
    step("mul_id", 1, 1, 1, 0, 0, 1, 0, 10, 1, 0, 0, 0, 0, 2'b00, 2'b00);
    for (int i = 0; i < 4; i++)
      step($sformatf("mul_busy%0d", i), 1, 10, 1, 0, 0, 1, 0, 11, 0, 0, 1, 0, 1, 2'b00, 2'b00);
    step("mul_next_id", 1, 10, 1, 0, 0, 1, 0, 11, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    nop("mul_next_ex", 0, 0, 2'b10, 2'b00);

    // Flush coinciding with load-use
    step("fl_ld", 1, 1, 1, 0, 0, 1, 1, 5, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    step("fl_lu", 1, 0, 0, 5, 1, 1, 0, 7, 0, 1, 0, 1, 0, 2'b00, 2'b00);
    step("fl_after", 1, 7, 1, 7, 1, 1, 0, 12, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    nop("fl_after_ex", 0, 0, 2'b00, 2'b00);

    // Reset in the 2nd BUSY cycle
    step("rst_mul", 1, 1, 1, 2, 1, 1, 0, 3, 1, 0, 0, 0, 0, 2'b00, 2'b00);
    step("rst_busy1", 1, 3, 1, 0, 0, 1, 0, 4, 0, 0, 1, 0, 1, 2'b00, 2'b00);
    #2 rst_i = 1'b1;
    #1;
    stall_total = 0;
    push_exp("rst_async", 0, 0, 0, 2'b00, 2'b00);
    pop_check();
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    step("post_rst_i1", 1, 1, 1, 2, 1, 1, 0, 3, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    step("post_rst_i2", 1, 2, 0, 3, 1, 1, 0, 6, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    nop("post_rst_i2_ex", 0, 0, 2'b00, 2'b01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
